// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: field widths, field positions,
// opcode names and small helpers for splitting and extending instruction fields.
package decode_stage_pkg;

    // Register file geometry
    localparam int DEF_NUM_REGS = 32;
    localparam int LEN_REGIDX   = 5;

    // Field widths of the bundle handed to execute
    localparam int LEN_OPECODE  = 6;
    localparam int LEN_IMMF     = 1;
    localparam int LEN_REG      = 32;
    localparam int LEN_CC       = 4;
    localparam int LEN_IMM_EX   = 32;
    localparam int LEN_IMM      = 16;
    localparam int LEN_INSN     = 32;

    // Field positions (lsb of each field) inside the instruction word
    localparam int POS_OPECODE  = 26;
    localparam int POS_IMMF     = 25;
    localparam int POS_CC       = 21;
    localparam int POS_RD       = 16;
    localparam int POS_RS       = 11;

    typedef enum logic [LEN_OPECODE-1:0] {
        OPECODE_NOP = 6'h00,
        OPECODE_ADD = 6'h01,
        OPECODE_SUB = 6'h02,
        OPECODE_AND = 6'h03,
        OPECODE_OR  = 6'h04,
        OPECODE_XOR = 6'h05,
        OPECODE_SHL = 6'h06,
        OPECODE_SHR = 6'h07
    } opecode_e;

    typedef struct packed {
        logic [LEN_OPECODE-1:0] opecode;
        logic [LEN_IMMF-1:0]    immf;
        logic [LEN_CC-1:0]      cc;
        logic [LEN_REGIDX-1:0]  rd;
        logic [LEN_REGIDX-1:0]  rs;
        logic [LEN_IMM-1:0]     imm;
    } insn_fields_t;

    // Slice an instruction word into its named fields; rs overlaps the top of imm.
    function automatic insn_fields_t split_insn(input logic [LEN_INSN-1:0] insn);
        insn_fields_t f;
        f.opecode = insn[POS_OPECODE +: LEN_OPECODE];
        f.immf    = insn[POS_IMMF    +: LEN_IMMF];
        f.cc      = insn[POS_CC      +: LEN_CC];
        f.rd      = insn[POS_RD      +: LEN_REGIDX];
        f.rs      = insn[POS_RS      +: LEN_REGIDX];
        f.imm     = insn[0           +: LEN_IMM];
        return f;
    endfunction

    // Sign-extend the 16-bit immediate to the execute operand width.
    function automatic logic [LEN_IMM_EX-1:0] sext_imm(input logic [LEN_IMM-1:0] imm);
        return {{(LEN_IMM_EX-LEN_IMM){imm[LEN_IMM-1]}}, imm};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Handshake, writeback and output-bundle signals of the decode stage.
// master = upstream/writeback/execute side, slave = the decode stage itself.
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [LEN_INSN-1:0]    insn;

    logic                   wb_en;
    logic [LEN_REGIDX-1:0]  wb_addr;
    logic [LEN_REG-1:0]     wb_data;

    logic                   out_valid;
    logic                   out_ready;
    logic [LEN_OPECODE-1:0] opecode;
    logic [LEN_IMMF-1:0]    immf;
    logic [LEN_CC-1:0]      cc;
    logic [LEN_REGIDX-1:0]  rd_addr;
    logic [LEN_REG-1:0]     data_rd;
    logic [LEN_REG-1:0]     data_rs;
    logic [LEN_IMM_EX-1:0]  imm_ex;

    modport master (
        output in_valid, insn, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, opecode, immf, cc, rd_addr,
               data_rd, data_rs, imm_ex
    );

    modport slave (
        input  in_valid, insn, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, opecode, immf, cc, rd_addr,
               data_rd, data_rs, imm_ex
    );

endinterface

// File: rtl/decode_stage_regfile.sv
// General-purpose register file: one write port, two combinational read ports.
// Entry 0 is hard-wired to zero; a read of the entry being written this cycle
// returns the incoming write data so a same-cycle consumer never sees stale data.
module decode_stage_regfile
    import decode_stage_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [LEN_REG-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr_a,
    output logic [LEN_REG-1:0] o_rdata_a,
    input  logic [AW-1:0]      i_raddr_b,
    output logic [LEN_REG-1:0] o_rdata_b
);

    logic [LEN_REG-1:0] r_mem [NUM_REGS];
    logic               w_wr_live;

    assign w_wr_live = i_we && (i_waddr != {AW{1'b0}});

    // Storage update; writes aimed at entry 0 are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= {LEN_REG{1'b0}};
            end
        end else if (w_wr_live) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port A with zero-register rule and write bypass
    always_comb begin
        o_rdata_a = {LEN_REG{1'b0}};
        if (i_raddr_a == {AW{1'b0}}) begin
            o_rdata_a = {LEN_REG{1'b0}};
        end else if (w_wr_live && (i_waddr == i_raddr_a)) begin
            o_rdata_a = i_wdata;
        end else begin
            o_rdata_a = r_mem[i_raddr_a];
        end
    end

    // Read port B with zero-register rule and write bypass
    always_comb begin
        o_rdata_b = {LEN_REG{1'b0}};
        if (i_raddr_b == {AW{1'b0}}) begin
            o_rdata_b = {LEN_REG{1'b0}};
        end else if (w_wr_live && (i_waddr == i_raddr_b)) begin
            o_rdata_b = i_wdata;
        end else begin
            o_rdata_b = r_mem[i_raddr_b];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode / register-read stage in front of execute. Splits the instruction,
// reads rd and rs from the register file and presents a registered bundle
// under a valid/ready handshake. While a bundle is held, writebacks to its
// source registers are folded into the held operands so it never goes stale.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.slave  bus
);

    // Decoded view of the incoming instruction
    insn_fields_t          w_fields;
    logic                  w_in_ready;
    logic                  w_capture;
    logic                  w_hold;
    logic                  w_wb_live;
    logic                  w_refresh_rd;
    logic                  w_refresh_rs;
    logic [LEN_REG-1:0]    w_rd_val;
    logic [LEN_REG-1:0]    w_rs_val;
    logic [LEN_REG-1:0]    w_data_rs;
    logic [LEN_IMM_EX-1:0] w_imm_ex;

    // Bundle registers presented to execute
    logic                   r_out_valid;
    logic [LEN_OPECODE-1:0] r_opecode;
    logic [LEN_IMMF-1:0]    r_immf;
    logic [LEN_CC-1:0]      r_cc;
    logic [LEN_REGIDX-1:0]  r_rd_addr;
    logic [LEN_REGIDX-1:0]  r_rs_addr;
    logic [LEN_REG-1:0]     r_data_rd;
    logic [LEN_REG-1:0]     r_data_rs;
    logic [LEN_IMM_EX-1:0]  r_imm_ex;

    decode_stage_regfile #(
        .NUM_REGS (NUM_REGS),
        .AW       (LEN_REGIDX)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (bus.wb_en),
        .i_waddr   (bus.wb_addr),
        .i_wdata   (bus.wb_data),
        .i_raddr_a (w_fields.rd),
        .o_rdata_a (w_rd_val),
        .i_raddr_b (w_fields.rs),
        .o_rdata_b (w_rs_val)
    );

    // Field split and operand/immediate selection for the incoming instruction
    always_comb begin
        w_fields  = split_insn(bus.insn);
        w_data_rs = {LEN_REG{1'b0}};
        w_imm_ex  = {LEN_IMM_EX{1'b0}};
        if (w_fields.immf == 1'b1) begin
            w_data_rs = {LEN_REG{1'b0}};
            w_imm_ex  = sext_imm(w_fields.imm);
        end else begin
            w_data_rs = w_rs_val;
            w_imm_ex  = {LEN_IMM_EX{1'b0}};
        end
    end

    // Handshake and refresh qualifiers
    always_comb begin
        w_in_ready   = !r_out_valid || bus.out_ready;
        w_capture    = bus.in_valid && w_in_ready;
        w_hold       = r_out_valid && !w_capture;
        w_wb_live    = bus.wb_en && (bus.wb_addr != {LEN_REGIDX{1'b0}});
        w_refresh_rd = w_hold && w_wb_live && (bus.wb_addr == r_rd_addr);
        w_refresh_rs = w_hold && w_wb_live && (r_immf == 1'b0)
                       && (bus.wb_addr == r_rs_addr);
    end

    // Bundle register: load on capture, drop valid on drain, refresh held operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_opecode   <= {LEN_OPECODE{1'b0}};
            r_immf      <= {LEN_IMMF{1'b0}};
            r_cc        <= {LEN_CC{1'b0}};
            r_rd_addr   <= {LEN_REGIDX{1'b0}};
            r_rs_addr   <= {LEN_REGIDX{1'b0}};
            r_data_rd   <= {LEN_REG{1'b0}};
            r_data_rs   <= {LEN_REG{1'b0}};
            r_imm_ex    <= {LEN_IMM_EX{1'b0}};
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_opecode   <= w_fields.opecode;
            r_immf      <= w_fields.immf;
            r_cc        <= w_fields.cc;
            r_rd_addr   <= w_fields.rd;
            r_rs_addr   <= w_fields.rs;
            r_data_rd   <= w_rd_val;
            r_data_rs   <= w_data_rs;
            r_imm_ex    <= w_imm_ex;
        end else begin
            r_out_valid <= r_out_valid && !bus.out_ready;
            if (w_refresh_rd) begin
                r_data_rd <= bus.wb_data;
            end
            if (w_refresh_rs) begin
                r_data_rs <= bus.wb_data;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.opecode   = r_opecode;
    assign bus.immf      = r_immf;
    assign bus.cc        = r_cc;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.data_rd   = r_data_rd;
    assign bus.data_rs   = r_data_rs;
    assign bus.imm_ex    = r_imm_ex;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vectors, a behavioural reference model of
// the stage checked every cycle, plus literal expectations at key points.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    decode_stage_if dif ();

    decode_stage #(.NUM_REGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [5:0]  m_op;
    logic        m_immf;
    logic [3:0]  m_cc;
    logic [4:0]  m_rd;
    logic [4:0]  m_rs;
    logic [31:0] m_data_rd;
    logic [31:0] m_data_rs;
    logic [31:0] m_imm_ex;
    logic        m_take;
    logic        m_wb;

    assign m_take = dif.in_valid && (!m_valid || dif.out_ready);
    assign m_wb   = dif.wb_en && (dif.wb_addr != 5'd0);

    // what a register reads as right now, including a write landing this cycle
    function automatic logic [31:0] reg_now(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (m_wb && dif.wb_addr == idx) return dif.wb_data;
        return m_regs[idx];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
            m_valid <= 1'b0; m_op <= 6'd0; m_immf <= 1'b0; m_cc <= 4'd0;
            m_rd <= 5'd0; m_rs <= 5'd0;
            m_data_rd <= 32'd0; m_data_rs <= 32'd0; m_imm_ex <= 32'd0;
        end else begin
            if (m_take) begin
                m_valid   <= 1'b1;
                m_op      <= dif.insn[31:26];
                m_immf    <= dif.insn[25];
                m_cc      <= dif.insn[24:21];
                m_rd      <= dif.insn[20:16];
                m_rs      <= dif.insn[15:11];
                m_data_rd <= reg_now(dif.insn[20:16]);
                m_data_rs <= dif.insn[25] ? 32'd0 : reg_now(dif.insn[15:11]);
                m_imm_ex  <= dif.insn[25] ? 32'($signed(dif.insn[15:0])) : 32'd0;
            end else if (m_valid) begin
                if (dif.out_ready) m_valid <= 1'b0;
                if (m_wb && dif.wb_addr == m_rd) m_data_rd <= dif.wb_data;
                if (m_wb && !m_immf && dif.wb_addr == m_rs) m_data_rs <= dif.wb_data;
            end
            if (m_wb) m_regs[dif.wb_addr] <= dif.wb_data;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 32'(dif.out_valid), 32'(m_valid));
            chk("in_ready", 32'(dif.in_ready), 32'(!m_valid || dif.out_ready));
            if (m_valid) begin
                chk("opecode", 32'(dif.opecode), 32'(m_op));
                chk("immf", 32'(dif.immf), 32'(m_immf));
                chk("cc", 32'(dif.cc), 32'(m_cc));
                chk("rd_addr", 32'(dif.rd_addr), 32'(m_rd));
                chk("data_rd", dif.data_rd, m_data_rd);
                chk("data_rs", dif.data_rs, m_data_rs);
                chk("imm_ex", dif.imm_ex, m_imm_ex);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [3:0] cc,
                                         input logic [4:0] rd, input logic [4:0] rs);
        return {op, 1'b0, cc, rd, rs, 11'h0A5};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [3:0] cc,
                                         input logic [4:0] rd, input logic [15:0] imm);
        return {op, 1'b1, cc, rd, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        dif.wb_en = 1'b1; dif.wb_addr = a; dif.wb_data = d;
        step();
        dif.wb_en = 1'b0;
    endtask

    logic [4:0]  b2b_rd   [4];
    logic [4:0]  b2b_rs   [4];
    logic [31:0] b2b_exp  [4];

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0;
        dif.in_valid = 1'b0; dif.insn = 32'd0; dif.out_ready = 1'b1;
        dif.wb_en = 1'b0; dif.wb_addr = 5'd0; dif.wb_data = 32'd0;
        #3;
        chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(dif.in_ready), 32'd1);
        chk("rst_data_rd", dif.data_rd, 32'd0);
        chk("rst_imm_ex", dif.imm_ex, 32'd0);
        chk("rst_opecode", 32'(dif.opecode), 32'd0);

        // untouched registers read 0
        dif.in_valid = 1'b1; dif.insn = mk_r(OPECODE_ADD, 4'h3, 5'd2, 5'd1);
        step(); dif.in_valid = 1'b0;
        chk("idle_rd_zero", dif.data_rd, 32'd0);
        chk("idle_rs_zero", dif.data_rs, 32'd0);
        step();

        // write then read
        wb(5'd3, 32'h1234_0000);
        wb(5'd4, 32'h0000_5678);
        dif.in_valid = 1'b1; dif.insn = mk_r(OPECODE_ADD, 4'h0, 5'd3, 5'd4);
        step(); dif.in_valid = 1'b0;
        chk("add_valid", 32'(dif.out_valid), 32'd1);
        chk("add_op", 32'(dif.opecode), 32'(OPECODE_ADD));
        chk("add_rd", dif.data_rd, 32'h1234_0000);
        chk("add_rs", dif.data_rs, 32'h0000_5678);
        chk("add_imm", dif.imm_ex, 32'd0);
        step();

        // immediate sign extension, two back-to-back
        wb(5'd5, 32'h0000_1234);
        dif.in_valid = 1'b1; dif.insn = mk_i(OPECODE_SHL, 4'hA, 5'd5, 16'hFFF8);
        step();
        chk("shl_rd", dif.data_rd, 32'h0000_1234);
        chk("shl_rs", dif.data_rs, 32'd0);
        chk("shl_imm_neg", dif.imm_ex, 32'hFFFF_FFF8);
        dif.insn = mk_i(OPECODE_SHL, 4'hA, 5'd5, 16'h0008);
        step(); dif.in_valid = 1'b0;
        chk("shl_imm_pos", dif.imm_ex, 32'h0000_0008);
        step();

        // bypass: capture and write r7 in the same cycle
        dif.in_valid = 1'b1; dif.insn = mk_r(OPECODE_SUB, 4'h1, 5'd7, 5'd0);
        dif.wb_en = 1'b1; dif.wb_addr = 5'd7; dif.wb_data = 32'hDEAD_BEEF;
        step(); dif.in_valid = 1'b0; dif.wb_en = 1'b0;
        chk("bypass_rd", dif.data_rd, 32'hDEAD_BEEF);
        step();
        wb(5'd0, 32'hFFFF_FFFF);
        dif.in_valid = 1'b1; dif.insn = mk_r(OPECODE_OR, 4'h2, 5'd0, 5'd0);
        step(); dif.in_valid = 1'b0;
        chk("r0_rd", dif.data_rd, 32'd0);
        chk("r0_rs", dif.data_rs, 32'd0);
        step();

        // stall and operand refresh
        wb(5'd9, 32'h0000_0001);
        dif.out_ready = 1'b0;
        dif.in_valid = 1'b1; dif.insn = mk_r(OPECODE_XOR, 4'h5, 5'd2, 5'd9);
        step();
        chk("stall_rs", dif.data_rs, 32'h0000_0001);
        chk("stall_in_ready", 32'(dif.in_ready), 32'd0);
        dif.insn = mk_r(OPECODE_AND, 4'h6, 5'd3, 5'd4);
        step();
        chk("stall_hold_op", 32'(dif.opecode), 32'(OPECODE_XOR));
        wb(5'd9, 32'h0000_0055);
        chk("refresh_rs", dif.data_rs, 32'h0000_0055);
        chk("refresh_rd_addr", 32'(dif.rd_addr), 32'd2);
        chk("refresh_cc", 32'(dif.cc), 32'h5);
        dif.out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(dif.in_ready), 32'd1);
        step(); dif.in_valid = 1'b0;
        chk("release_op", 32'(dif.opecode), 32'(OPECODE_AND));
        chk("release_rd", dif.data_rd, 32'h1234_0000);
        chk("release_rs", dif.data_rs, 32'h0000_5678);
        step();

        // back-to-back then asynchronous reset mid-stream
        b2b_rd[0] = 5'd3; b2b_rs[0] = 5'd4; b2b_exp[0] = 32'h1234_0000;
        b2b_rd[1] = 5'd4; b2b_rs[1] = 5'd3; b2b_exp[1] = 32'h0000_5678;
        b2b_rd[2] = 5'd5; b2b_rs[2] = 5'd9; b2b_exp[2] = 32'h0000_1234;
        b2b_rd[3] = 5'd7; b2b_rs[3] = 5'd2; b2b_exp[3] = 32'hDEAD_BEEF;
        dif.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dif.insn = mk_r(OPECODE_ADD, 4'(k), b2b_rd[k], b2b_rs[k]);
            step();
            chk("b2b_valid", 32'(dif.out_valid), 32'd1);
            chk("b2b_rd_addr", 32'(dif.rd_addr), 32'(b2b_rd[k]));
            chk("b2b_data_rd", dif.data_rd, b2b_exp[k]);
        end
        #1;
        rst_n = 1'b0; dif.in_valid = 1'b0;
        #1;
        chk("async_rst_valid", 32'(dif.out_valid), 32'd0);
        chk("async_rst_data", dif.data_rd, 32'd0);
        step();
        rst_n = 1'b1;
        dif.in_valid = 1'b1; dif.insn = mk_r(OPECODE_ADD, 4'h0, 5'd3, 5'd4);
        step(); dif.in_valid = 1'b0;
        chk("post_rst_rd", dif.data_rd, 32'd0);
        chk("post_rst_rs", dif.data_rs, 32'd0);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode/register-read pipeline stage directly upstream of execute.
- Accepts 32-bit instruction words over a valid/ready handshake and splits them into fields.
- Reads the two source operands from an internal 32x32 register file, which receives its writes from the writeback port.
- Presents a registered, handshaked bundle whose fields (opecode, immf, data_rd, data_rs, cc, imm_ex) connect one-to-one to execute's inputs.

Parameters:
- NUM_REGS, 32, register file depth; register index width = $clog2(NUM_REGS) = 5.
- Field-width constants LEN_OPECODE=6, LEN_IMMF=1, LEN_REG=32, LEN_CC=4, LEN_IMM_EX=32 come from defs_insn.v, included in the parameter list.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  insn is valid this cycle.
- in_ready  out  1  stage can accept insn this cycle.
- insn  in  32  instruction word.
- wb_en  in  1  register file write enable from writeback.
- wb_addr  in  5  write index.
- wb_data  in  LEN_REG  write data.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  execute/downstream accepts the bundle.
- opecode  out  LEN_OPECODE  insn[31:26].
- immf  out  LEN_IMMF  insn[25].
- cc  out  LEN_CC  insn[24:21].
- rd_addr  out  5  insn[20:16], forwarded for writeback.
- data_rd  out  LEN_REG  value of register rd.
- data_rs  out  LEN_REG  value of register rs (insn[15:11]); 0 when immf=1.
- imm_ex  out  LEN_IMM_EX  insn[15:0] sign-extended when immf=1, else 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0; all bundle outputs 0.
  - All register file entries 0.
  - Reset mid-transfer discards the held bundle.
- in_ready = !out_valid || out_ready (combinational; no bubble under continuous flow).
- Capture: on clk rising edge with in_valid && in_ready:
  - Bundle registers load the decoded fields.
  - out_valid is set to 1 on the next cycle, giving 1-cycle latency from accept to presentation.
- Drain: out_valid && out_ready with no capture sets out_valid to 0. Bundle values are then don't-care, but the design holds them.
- Stall: while out_valid && !out_ready, every bundle output holds stable. Sole exception: the operand refresh rule below.
- Register file:
  - Write occurs on clk edge when wb_en && wb_addr!=0.
  - r0 reads as 0 always; writes to r0 are ignored.
- Read-during-write bypass: at capture, if wb_en && wb_addr==field && field!=0, the captured operand is wb_data, not the stale entry. Applies to rd and rs independently.
- Operand refresh during stall: while the bundle is held (out_valid && !capture), a write with wb_en && wb_addr==rd_addr && wb_addr!=0 also updates data_rd. Same rule for data_rs, against the held rs index, only when immf=0. The held bundle therefore never carries stale operands.
- immf=1: data_rs=0; rs index not used for bypass or refresh.
- Simultaneous drain and capture in the same cycle: new bundle loads, out_valid stays 1.
- in_valid low with in_ready high: no state change except register file writes.

Decomposition:
- defs_insn.v (shared include) gains the field position constants: POS_OPECODE=26, POS_IMMF=25, POS_CC=21, POS_RD=16, POS_RS=11, LEN_IMM=16, LEN_REGIDX=5.
- Sub-module regfile:
  - Inputs: clk, rst_n, one write port, two combinational read ports.
  - Owns the r0 rule and the write-bypass.
  - decode_stage owns decode, the bundle registers, the handshake and the stall refresh.

Test Plan:
- Reset then idle:
  - All outputs 0, out_valid=0, in_ready=1.
  - Reading any register via an insn returns 0.
- Write then read:
  - wb r3=0x1234_0000, wb r4=0x0000_5678.
  - Then insn ADD rd=3, rs=4, immf=0.
  - Next cycle: out_valid=1, opecode=OPECODE_ADD, data_rd=0x1234_0000, data_rs=0x0000_5678, imm_ex=0.
- Immediate sign extension:
  - insn SHL, immf=1, imm16=0xFFF8, rd=5 with r5=0x0000_1234.
  - Expect data_rd=0x0000_1234, data_rs=0, imm_ex=0xFFFF_FFF8.
  - Repeat with imm16=0x0008: expect imm_ex=0x0000_0008.
- Bypass:
  - In the same cycle, capture insn rd=7 and wb r7=0xDEAD_BEEF (r7 previously 0).
  - Expect data_rd=0xDEAD_BEEF.
  - wb to r0 with 0xFFFF_FFFF: a later read of r0 gives 0.
- Stall and refresh:
  - Hold out_ready=0 with bundle rs=9 and data_rs=0x1; in_ready=0, so a new in_valid is not accepted.
  - wb r9=0x55 gives data_rs=0x55 next cycle, while other fields are unchanged.
  - Raise out_ready: the pending insn is captured in the same cycle.
- Back-to-back and reset:
  - 4 insns with in_valid and out_ready held at 1: one bundle per cycle, in order, no bubbles.
  - Assert rst_n=0 mid-stream: out_valid drops immediately without waiting for a clock edge, and registers read 0 afterwards.
